// File: rtl/cordic_rot_seq.sv
// cordic_rot_seq
// Iterative rotation-mode CORDIC producing cos/sin of an 8-bit signed angle
// (128 = pi). The angle is folded into +/-pi/2 on load. One micro-rotation
// runs per clock. Results are offered on a valid/ready handshake.
module cordic_rot_seq #(
  parameter int ITER   = 8,
  parameter int K_INIT = 39
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] angle_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] cos_out,
  output logic [7:0] sin_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0]        LAST_ITER = 3'(ITER - 1);
  localparam logic signed [7:0] K_POS     = 8'(K_INIT);
  localparam logic signed [7:0] K_NEG     = 8'(-K_INIT);

  state_t state, state_nxt;

  logic signed [7:0] x, y, z;
  logic [2:0]        cnt;

  logic              accept;
  logic              last_rot;

  logic signed [7:0] theta;
  logic signed [7:0] x_load, z_load;

  logic signed [7:0] x_sh, y_sh, atan_i;
  logic              dir_pos;
  logic signed [7:0] x_rot, y_rot, z_rot;

  // arctan(2^-i) in the same angle units as angle_in (128 = pi)
  function automatic logic signed [7:0] atan_lut(input logic [2:0] idx);
    logic signed [7:0] val;
    case (idx)
      3'd0:    val = 8'sd32;
      3'd1:    val = 8'sd19;
      3'd2:    val = 8'sd10;
      3'd3:    val = 8'sd5;
      3'd4:    val = 8'sd3;
      3'd5:    val = 8'sd1;
      3'd6:    val = 8'sd1;
      default: val = 8'sd0;
    endcase
    return val;
  endfunction

  assign accept   = in_valid && in_ready;
  assign last_rot = (state == RUN) && (cnt == LAST_ITER);

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  // Fold the incoming angle into [-pi/2, +pi/2]; outside that range the start
  // vector is negated and z moves by pi, which is just an MSB flip mod 256
  always_comb begin
    theta  = angle_in;
    x_load = K_POS;
    z_load = theta;
    if (theta > 8'sd64 || theta < -8'sd64) begin
      x_load = K_NEG;
      z_load = {~angle_in[7], angle_in[6:0]};
    end
  end

  // One micro-rotation step driven by the sign of the residual angle z
  always_comb begin
    x_sh    = x >>> cnt;
    y_sh    = y >>> cnt;
    atan_i  = atan_lut(cnt);
    dir_pos = ~z[7];
    x_rot   = x + y_sh;
    y_rot   = y - x_sh;
    z_rot   = z + atan_i;
    if (dir_pos) begin
      x_rot = x - y_sh;
      y_rot = y + x_sh;
      z_rot = z - atan_i;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE accepts, RUN counts rotations, DONE waits for consumer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_rot)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rotation datapath and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x   <= '0;
      y   <= '0;
      z   <= '0;
      cnt <= '0;
    end else if (accept) begin
      x   <= x_load;
      y   <= '0;
      z   <= z_load;
      cnt <= '0;
    end else if (state == RUN) begin
      x   <= x_rot;
      y   <= y_rot;
      z   <= z_rot;
      cnt <= last_rot ? 3'd0 : cnt + 3'd1;
    end
  end

  // Result registers capture the final rotation and hold through backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cos_out <= '0;
      sin_out <= '0;
    end else if (last_rot) begin
      cos_out <= x_rot;
      sin_out <= y_rot;
    end
  end

endmodule

// File: tb/tb_cordic_rot_seq.sv
// tb_cordic_rot_seq
// Scoreboard bench for cordic_rot_seq: expected cos/sin are computed by a
// reference CORDIC model when an angle is driven and compared on completion.
module tb_cordic_rot_seq;

  localparam int ITER   = 8;
  localparam int K_INIT = 39;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] angle_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] cos_out;
  logic [7:0] sin_out;
  logic       busy;

  typedef struct {
    logic signed [7:0] cos_exp;
    logic signed [7:0] sin_exp;
    int                cos_ideal;
    int                sin_ideal;
  } exp_t;

  exp_t sb[$];

  int tests_run    = 0;
  int tests_failed = 0;

  cordic_rot_seq #(.ITER(ITER), .K_INIT(K_INIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_in  (angle_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out),
    .sin_out   (sin_out),
    .busy      (busy)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Count one comparison and report it when the values differ
  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  // Reference CORDIC: fold, then ITER micro-rotations with 8-bit truncating math
  function automatic void model(input logic signed [7:0] a,
                                output logic signed [7:0] c,
                                output logic signed [7:0] s);
    int                atan_t[8] = '{32, 19, 10, 5, 3, 1, 1, 0};
    logic signed [7:0] xm, ym, zm, xt, at;
    ym = 8'sd0;
    if (a > 8'sd64) begin
      xm = 8'(-K_INIT);
      zm = 8'(int'(a) - 128);
    end else if (a < -8'sd64) begin
      xm = 8'(-K_INIT);
      zm = 8'(int'(a) + 128);
    end else begin
      xm = 8'(K_INIT);
      zm = a;
    end
    for (int i = 0; i < ITER; i++) begin
      at = 8'(atan_t[i]);
      if (zm >= 0) begin
        xt = xm - (ym >>> i);
        ym = ym + (xm >>> i);
        zm = zm - at;
      end else begin
        xt = xm + (ym >>> i);
        ym = ym - (xm >>> i);
        zm = zm + at;
      end
      xm = xt;
    end
    c = xm;
    s = ym;
  endfunction

  // Drive one angle from IDLE and push its expected result on the accept edge
  task automatic applyStimulus(input logic signed [7:0] a, input int ic, input int is);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    angle_in = a;
    @(posedge clk);
    model(a, e.cos_exp, e.sin_exp);
    e.cos_ideal = ic;
    e.sin_ideal = is;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid after an accept edge; returns cycles in RUN
  task automatic wait_result(input string tag, output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checkOutput({tag, "_busy"}, int'(busy), 1);
        checkOutput({tag, "_in_ready_run"}, int'(in_ready), 0);
      end
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput({tag, "_latency"}, lat, ITER);
  endtask

  // Pop the scoreboard and compare both the exact and the approximate result
  task automatic compare_result(input string tag);
    exp_t e;
    int   dc, ds;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e  = sb.pop_front();
    checkOutput({tag, "_cos"}, int'($signed(cos_out)), int'(e.cos_exp));
    checkOutput({tag, "_sin"}, int'($signed(sin_out)), int'(e.sin_exp));
    dc = int'($signed(cos_out)) - e.cos_ideal;
    ds = int'($signed(sin_out)) - e.sin_ideal;
    checkOutput({tag, "_cos_tol"}, int'(dc <= 3 && dc >= -3), 1);
    checkOutput({tag, "_sin_tol"}, int'(ds <= 3 && ds >= -3), 1);
  endtask

  // Retire the result currently offered
  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_retired"}, int'(out_valid), 0);
    checkOutput({tag, "_idle_ready"}, int'(in_ready), 1);
  endtask

  typedef struct {
    logic signed [7:0] a;
    int                ic;
    int                is;
    string             tag;
  } vec_t;

  // Main sequence
  initial begin
    vec_t vecs[6];
    int   lat;
    int   seen;
    logic [7:0] hold_cos, hold_sin;

    vecs[0] = '{8'sd0,    64,  0,   "ang0"};
    vecs[1] = '{8'sd32,   45,  45,  "ang32"};
    vecs[2] = '{8'sd64,   0,   64,  "ang64"};
    vecs[3] = '{-8'sd64,  0,   -64, "angm64"};
    vecs[4] = '{8'sd96,   -45, 45,  "ang96"};
    vecs[5] = '{-8'sd128, -64, 0,   "angm128"};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    angle_in  = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_cos", int'(cos_out), 0);
    checkOutput("rst_sin", int'(sin_out), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rel_in_ready", int'(in_ready), 1);

    // Main function over the angle table
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].a, vecs[v].ic, vecs[v].is);
      wait_result(vecs[v].tag, lat);
      compare_result(vecs[v].tag);
      retire(vecs[v].tag);
    end

    // Backpressure: hold result for 20 cycles while in_valid pulses are ignored
    applyStimulus(8'sd96, -45, 45);
    wait_result("bp", lat);
    hold_cos = cos_out;
    hold_sin = sin_out;
    compare_result("bp");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = (c % 3 == 0);
      angle_in = 8'd10;
      #1;
      checkOutput("bp_cos_stable", int'(cos_out), int'(hold_cos));
      checkOutput("bp_sin_stable", int'(sin_out), int'(hold_sin));
      checkOutput("bp_valid_held", int'(out_valid), 1);
      checkOutput("bp_in_ready", int'(in_ready), 0);
    end

    // Retire and offer a new angle in the same cycle: accepted one cycle later
    @(negedge clk);
    in_valid  = 1'b1;
    angle_in  = 8'sd32;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("same_cycle_valid", int'(out_valid), 0);
    checkOutput("same_cycle_not_busy", int'(busy), 0);
    checkOutput("same_cycle_in_ready", int'(in_ready), 1);
    begin
      exp_t e;
      @(posedge clk);
      model(8'sd32, e.cos_exp, e.sin_exp);
      e.cos_ideal = 45;
      e.sin_ideal = 45;
      sb.push_back(e);
      #1;
      in_valid = 1'b0;
    end
    wait_result("late_accept", lat);
    compare_result("late_accept");

    // Asynchronous reset asserted mid-clock while in DONE
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", int'(out_valid), 0);
    checkOutput("mid_rst_cos", int'(cos_out), 0);
    checkOutput("mid_rst_sin", int'(sin_out), 0);
    checkOutput("mid_rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_release", int'(in_ready), 1);

    // Reset pulse during RUN at iteration 4 aborts the angle
    applyStimulus(8'sd64, 0, 64);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_valid", int'(out_valid), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checkOutput("abort_no_valid", seen, 0);
    checkOutput("abort_idle", int'(in_ready), 1);

    // Recovery: next angle after abort behaves normally
    applyStimulus(8'sd0, 64, 0);
    wait_result("recover", lat);
    compare_result("recover");
    retire("recover");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
